// File: rtl/instr_stat_profiler.sv
// Retired-instruction statistics: live R/I/J/SYS/TOTAL counters, shadow snapshot bank,
// sticky overflow and a syscall $a0 latch. Define STAT_CYCLE_CNT_EN to build the cycle counter.
//
//   state  | meaning
//   RUN    | retires (and cycles) are counted
//   FROZEN | live counters hold; snap, clear, read port and syscall latch still active

module instr_stat_profiler #(
    parameter int          CNT_W         = 32,
    parameter bit          SATURATE      = 1'b1,
    parameter logic [5:0]  SYSCALL_FUNCT = 6'h0C
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             retire_valid,
    input  logic [31:0]      instr,
    input  logic [31:0]      a0_val,
    input  logic             clear,
    input  logic             freeze,
    input  logic             snap,
    input  logic [2:0]       rd_sel,
    output logic [CNT_W-1:0] rd_data,
    output logic [31:0]      hex_out,
    output logic             sys_pending,
    output logic             ovf
);

    localparam int IDX_R   = 0;
    localparam int IDX_I   = 1;
    localparam int IDX_J   = 2;
    localparam int IDX_SYS = 3;
    localparam int IDX_TOT = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        RUN    = 1'b0,
        FROZEN = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       is_sys;
    logic       is_r;
    logic       is_j;
    logic       is_i;
    logic       unused_instr;

    logic [4:0]            hit;
    logic [4:0][CNT_W-1:0] live_q;
    logic [4:0][CNT_W-1:0] live_d;
    logic [4:0][CNT_W-1:0] shadow_q;
    logic                  ovf_set;
    logic [CNT_W-1:0]      rd_mux;

`ifdef STAT_CYCLE_CNT_EN
    logic [CNT_W-1:0] cyc_q;
    logic [CNT_W-1:0] cyc_d;
    logic [CNT_W-1:0] shadow_cyc_q;
`endif

    function automatic logic [CNT_W-1:0] bump_val(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return SATURATE ? CNT_MAX : '0;
        end
        return v + CNT_W'(1);
    endfunction

    assign opcode       = instr[31:26];
    assign funct        = instr[5:0];
    assign is_sys       = (opcode == 6'd0) && (funct == SYSCALL_FUNCT);
    assign is_r         = (opcode == 6'd0) && !is_sys;
    assign is_j         = (opcode == 6'd2) || (opcode == 6'd3);
    assign is_i         = !is_sys && !is_r && !is_j;
    assign unused_instr = &{1'b0, instr[25:6]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (freeze)  state_d = FROZEN;
            FROZEN:  if (!freeze) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Each counter overflows independently; any of them can raise the shared sticky flag.
    always_comb begin
        hit     = '0;
        live_d  = live_q;
        ovf_set = 1'b0;
        if (retire_valid && (state_q == RUN)) begin
            hit[IDX_TOT] = 1'b1;
            hit[IDX_SYS] = is_sys;
            hit[IDX_R]   = is_r;
            hit[IDX_J]   = is_j;
            hit[IDX_I]   = is_i;
        end
        for (int k = 0; k < 5; k++) begin
            if (hit[k]) begin
                live_d[k] = bump_val(live_q[k]);
                if (live_q[k] == CNT_MAX) ovf_set = 1'b1;
            end
        end
`ifdef STAT_CYCLE_CNT_EN
        cyc_d = cyc_q;
        if (state_q == RUN) begin
            cyc_d = bump_val(cyc_q);
            if (cyc_q == CNT_MAX) ovf_set = 1'b1;
        end
`endif
    end

    // clear wins over everything except hex_out, which keeps the last syscall value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_q      <= '0;
            shadow_q    <= '0;
            ovf         <= 1'b0;
            sys_pending <= 1'b0;
            hex_out     <= '0;
        end else if (clear) begin
            live_q      <= '0;
            shadow_q    <= '0;
            ovf         <= 1'b0;
            sys_pending <= 1'b0;
        end else begin
            live_q <= live_d;
            if (snap) shadow_q <= live_q;
            if (ovf_set) ovf <= 1'b1;
            if (retire_valid && is_sys) begin
                hex_out     <= a0_val;
                sys_pending <= 1'b1;
            end
        end
    end

`ifdef STAT_CYCLE_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q        <= '0;
            shadow_cyc_q <= '0;
        end else if (clear) begin
            cyc_q        <= '0;
            shadow_cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            if (snap) shadow_cyc_q <= cyc_q;
        end
    end
`endif

    always_comb begin
        rd_mux = '0;
        case (rd_sel)
            3'd0: rd_mux = shadow_q[IDX_R];
            3'd1: rd_mux = shadow_q[IDX_I];
            3'd2: rd_mux = shadow_q[IDX_J];
            3'd3: rd_mux = shadow_q[IDX_SYS];
            3'd4: rd_mux = shadow_q[IDX_TOT];
`ifdef STAT_CYCLE_CNT_EN
            3'd5: rd_mux = shadow_cyc_q;
`endif
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_mux;
        end
    end

endmodule

// File: tb/tb_instr_stat_profiler.sv
// Directed bench for instr_stat_profiler: a 32-bit instance plus 8-bit saturating
// and wrapping instances, all driven by the same stimulus.

module tb_instr_stat_profiler;

    localparam logic [31:0] I_ADD  = 32'h012A4020;
    localparam logic [31:0] I_ADDI = 32'h20080005;
    localparam logic [31:0] I_J    = 32'h08000010;
    localparam logic [31:0] I_SYS  = 32'h0000000C;

    logic        clk = 1'b0;
    logic        rst;
    logic        retire_valid;
    logic [31:0] instr;
    logic [31:0] a0_val;
    logic        clear;
    logic        freeze;
    logic        snap;
    logic [2:0]  rd_sel;

    logic [31:0] m_rd;
    logic [31:0] m_hex;
    logic        m_pend;
    logic        m_ovf;
    logic [7:0]  s_rd;
    logic [31:0] s_hex;
    logic        s_pend;
    logic        s_ovf;
    logic [7:0]  w_rd;
    logic [31:0] w_hex;
    logic        w_pend;
    logic        w_ovf;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    instr_stat_profiler u_main (
        .clk(clk), .rst(rst), .retire_valid(retire_valid), .instr(instr), .a0_val(a0_val),
        .clear(clear), .freeze(freeze), .snap(snap), .rd_sel(rd_sel),
        .rd_data(m_rd), .hex_out(m_hex), .sys_pending(m_pend), .ovf(m_ovf)
    );

    instr_stat_profiler #(.CNT_W(8), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .retire_valid(retire_valid), .instr(instr), .a0_val(a0_val),
        .clear(clear), .freeze(freeze), .snap(snap), .rd_sel(rd_sel),
        .rd_data(s_rd), .hex_out(s_hex), .sys_pending(s_pend), .ovf(s_ovf)
    );

    instr_stat_profiler #(.CNT_W(8), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .retire_valid(retire_valid), .instr(instr), .a0_val(a0_val),
        .clear(clear), .freeze(freeze), .snap(snap), .rd_sel(rd_sel),
        .rd_data(w_rd), .hex_out(w_hex), .sys_pending(w_pend), .ovf(w_ovf)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input logic [31:0] iw, input logic [31:0] a0);
        retire_valid = 1'b1;
        instr        = iw;
        a0_val       = a0;
        tick();
        retire_valid = 1'b0;
    endtask

    task automatic do_snap();
        snap = 1'b1;
        tick();
        snap = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic read_sel(input logic [2:0] sel);
        rd_sel = sel;
        tick();
    endtask

    initial begin
        rst = 1'b1; retire_valid = 1'b0; instr = '0; a0_val = '0;
        clear = 1'b0; freeze = 1'b0; snap = 1'b0; rd_sel = 3'd0;
        #20;
        rst = 1'b0;
        check("reset_rd",   64'(m_rd),   64'd0);
        check("reset_hex",  64'(m_hex),  64'd0);
        check("reset_pend", 64'(m_pend), 64'd0);
        check("reset_ovf",  64'(m_ovf),  64'd0);
        tick();

        // class mix
        retire(I_ADD, 32'h0);
        retire(I_ADDI, 32'h0);
        retire(I_J, 32'h0);
        retire(I_SYS, 32'h1234);
        do_snap();
        read_sel(3'd0); check("mix_r",   64'(m_rd), 64'd1);
        read_sel(3'd1); check("mix_i",   64'(m_rd), 64'd1);
        read_sel(3'd2); check("mix_j",   64'(m_rd), 64'd1);
        read_sel(3'd3); check("mix_sys", 64'(m_rd), 64'd1);
        read_sel(3'd4); check("mix_tot", 64'(m_rd), 64'd4);
        read_sel(3'd6); check("mix_sel6", 64'(m_rd), 64'd0);
        check("mix_hex",  64'(m_hex),  64'h1234);
        check("mix_pend", 64'(m_pend), 64'd1);

        // freeze
        do_clear();
        repeat (3) retire(I_ADD, 32'h0);
        freeze = 1'b1;
        tick();
        repeat (5) retire(I_ADD, 32'h0);
        retire(I_SYS, 32'hABCD);
        freeze = 1'b0;
        tick();
        repeat (2) retire(I_ADD, 32'h0);
        do_snap();
        read_sel(3'd0); check("frz_r",   64'(m_rd), 64'd5);
        read_sel(3'd4); check("frz_tot", 64'(m_rd), 64'd5);
        read_sel(3'd3); check("frz_sys", 64'(m_rd), 64'd0);
        check("frz_hex",  64'(m_hex),  64'hABCD);
        check("frz_pend", 64'(m_pend), 64'd1);

        // snap/retire collision
        do_clear();
        repeat (7) retire(I_ADD, 32'h0);
        snap = 1'b1;
        retire(I_ADD, 32'h0);
        snap = 1'b0;
        read_sel(3'd0); check("col_r_old", 64'(m_rd), 64'd7);
        do_snap();
        read_sel(3'd0); check("col_r_new", 64'(m_rd), 64'd8);
        read_sel(3'd4); check("col_tot",   64'(m_rd), 64'd8);

        // overflow on the 8-bit instances
        do_clear();
        repeat (256) retire(I_ADDI, 32'h0);
        do_snap();
        read_sel(3'd1);
        check("ovf_main_i", 64'(m_rd), 64'd256);
        check("ovf_sat_i",  64'(s_rd), 64'd255);
        check("ovf_wrap_i", 64'(w_rd), 64'd0);
        read_sel(3'd4);
        check("ovf_sat_tot",  64'(s_rd), 64'd255);
        check("ovf_wrap_tot", 64'(w_rd), 64'd0);
        check("ovf_main_flag", 64'(m_ovf), 64'd0);
        check("ovf_sat_flag",  64'(s_ovf), 64'd1);
        check("ovf_wrap_flag", 64'(w_ovf), 64'd1);

        // asynchronous reset between edges
        do_clear();
        repeat (10) retire(I_ADD, 32'h0);
        retire(I_SYS, 32'h77);
        do_snap();
        read_sel(3'd4);
        check("arst_pre_rd",  64'(m_rd),  64'd11);
        check("arst_pre_hex", 64'(m_hex), 64'h77);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("arst_rd",       64'(m_rd),   64'd0);
        check("arst_hex",      64'(m_hex),  64'd0);
        check("arst_pend",     64'(m_pend), 64'd0);
        check("arst_sat_ovf",  64'(s_ovf),  64'd0);
        check("arst_wrap_rd",  64'(w_rd),   64'd0);
        #1 rst = 1'b0;
        tick();

        // clear beats a simultaneous syscall retire; hex_out survives
        retire(I_SYS, 32'h1234);
        repeat (3) retire(I_ADD, 32'h0);
        check("clr_pre_pend", 64'(m_pend), 64'd1);
        clear = 1'b1;
        retire(I_SYS, 32'hBEEF);
        clear = 1'b0;
        check("clr_hex",  64'(m_hex),  64'h1234);
        check("clr_pend", 64'(m_pend), 64'd0);
        check("clr_ovf",  64'(m_ovf),  64'd0);
        do_snap();
        read_sel(3'd0); check("clr_r",   64'(m_rd), 64'd0);
        read_sel(3'd3); check("clr_sys", 64'(m_rd), 64'd0);
        read_sel(3'd4); check("clr_tot", 64'(m_rd), 64'd0);

        // cycle counter
        do_clear();
        repeat (20) tick();
        do_snap();
        read_sel(3'd5);
`ifdef STAT_CYCLE_CNT_EN
        check("cyc_20", 64'(m_rd), 64'd20);
`else
        check("cyc_off", 64'(m_rd), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_stat_profiler.md
Name: instr_stat_profiler

Overview:
- Parametrised successor to the fixed 32-bit R/I/J/total statistics counters in single_cycle_cpu_top.
- Classifies each retired instruction into R, I, J or SYSCALL and keeps live per-class and total counters.
- Adds a shadow snapshot bank with an indexed read port, freeze/clear control, saturate-or-wrap overflow handling, and a syscall hex latch that captures $a0.
- Sits beside the CPU core, fed by the retire strobe and the current instruction word.

Parameters:
- CNT_W, 32, counter width in bits, legal range 8..64.
- SATURATE, 1: 1 means counters stick at all-ones; 0 means counters wrap to 0.
- SYSCALL_FUNCT, 6'h0C, funct field that marks a syscall when opcode==0.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- retire_valid  in  1  one instruction retires this cycle.
- instr  in  32  retiring instruction word.
- a0_val  in  32  current $a0 register value.
- clear  in  1  synchronous clear of live counters, shadow bank, ovf and sys_pending.
- freeze  in  1  level: hold live counters.
- snap  in  1  pulse: copy live counters into the shadow bank.
- rd_sel  in  3  shadow index: 0=R, 1=I, 2=J, 3=SYS, 4=TOTAL, 5=CYCLE, 6..7 read as 0.
- rd_data  out  CNT_W  registered shadow read data.
- hex_out  out  32  $a0 value latched at the last syscall.
- sys_pending  out  1  sticky flag: a syscall has retired since the last clear.
- ovf  out  1  sticky flag: some counter reached max and was incremented again.

Behaviour:
- Reset (asynchronous, rst=1): every counter, every shadow, rd_data, hex_out, sys_pending and ovf go to 0. FSM goes to RUN.
- Classification uses opcode=instr[31:26] and funct=instr[5:0]:
  - SYS: opcode==0 and funct==SYSCALL_FUNCT.
  - R: opcode==0 and not SYS.
  - J: opcode==2 or opcode==3.
  - I: everything else.
  - Exactly one class counter is bumped per retire.
- TOTAL increments on every counted retire, so TOTAL == R+I+J+SYS until a counter saturates or wraps.
- FSM:
  - Two states, RUN and FROZEN.
  - RUN -> FROZEN when freeze=1. FROZEN -> RUN when freeze=0. The transition is registered and takes effect the next cycle.
  - In FROZEN, retires are ignored by the counters. Snap, clear, the hex latch and rd_data still operate.
- Latency:
  - A retire at edge N is visible in the live counters after edge N.
  - snap at edge N captures the live values held before edge N; the same-cycle retire is excluded.
  - rd_data reflects shadow[rd_sel] one cycle after rd_sel is presented (registered mux).
- Overflow:
  - Incrementing a counter already at 2^CNT_W-1 sets ovf, which stays set until clear or rst.
  - SATURATE=1: the counter holds at max.
  - SATURATE=0: the counter goes to 0.
  - TOTAL follows the same rule independently.
- Syscall latch: a SYS retire with retire_valid=1 loads hex_out<=a0_val and sets sys_pending. This happens in both RUN and FROZEN.
- Priority and simultaneous events:
  - clear beats snap, retire and the syscall latch. All live counters, all shadows, ovf and sys_pending go to 0 and the retire is dropped. hex_out is preserved.
  - snap together with a retire: the shadow gets the old values and the live counters increment.
  - retire_valid=0: instr is ignored entirely.
- CYCLE counter: increments every cycle in RUN, obeys the overflow rules, and is cleared by clear.
- Reset asserted mid-operation aborts any in-flight snap or read. Outputs go to 0 immediately, without waiting for a clock edge.

Optional Feature:
- Macro: STAT_CYCLE_CNT_EN.
- Defined: the CYCLE live counter and its shadow exist; rd_sel=5 returns the snapshotted cycle count.
- Undefined: no cycle counter logic is built; rd_sel=5 reads 0; ovf never sets from cycle counting.

Test Plan:
- Reset/class mix: rst high 20 ns then low. Retire 0x012A4020 (add), 0x20080005 (addi), 0x08000010 (j), 0x0000000C (syscall) with a0_val=0x1234. Then snap and read sel 0..4 -> 1,1,1,1,4. hex_out=0x00001234, sys_pending=1.
- Freeze: retire 3 adds, assert freeze, retire 5 adds, deassert freeze, retire 2 adds, snap -> R=5, TOTAL=5. A syscall during the freeze still updates hex_out.
- Snap/retire collision: live R=7; snap and an add retire on the same edge -> shadow R=7, next snap R=8.
- Overflow with CNT_W=8:
  - SATURATE=1: 256 addi retires -> I=255, ovf=1.
  - SATURATE=0: 256 addi retires -> I=0, ovf=1.
- Clear priority: clear together with a syscall retire (a0_val=0xBEEF), previous hex_out=0x1234 -> all counters 0, sys_pending=0, ovf=0, hex_out stays 0x1234.
- Async reset mid-run: assert rst between clock edges after 10 retires -> rd_data, hex_out, ovf go to 0 before the next edge. With STAT_CYCLE_CNT_EN, 20 RUN cycles then snap -> rd_sel=5 reads 20. Without it, rd_sel=5 reads 0.
